// File: rtl/prio_task_queue.sv
// Multi-level priority task queue: one circular FIFO per level, strict-priority grant.
// Optional anti-starvation grant override is compiled in with PRIO_TASK_QUEUE_ANTI_STARVE_EN.
module prio_task_queue #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned NUM_PRIO     = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned PW = (NUM_PRIO > 1) ? $clog2(NUM_PRIO) : 1,
  localparam int unsigned CW = $clog2(NUM_PRIO * DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PW-1:0]     in_prio,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PW-1:0]     out_prio,
  input  logic              flush,
  output logic [CW-1:0]     count,
  output logic              overflow
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned OW   = AW + 1;
  localparam int unsigned NSEL = 2 ** PW;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NUM_PRIO < 2 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("prio_task_queue: illegal parameter combination");
  end

  logic [DATA_W-1:0]           mem_q [NUM_PRIO][DEPTH];
  logic [NUM_PRIO-1:0][AW-1:0] head_q, head_d;
  logic [NUM_PRIO-1:0][AW-1:0] tail_q, tail_d;
  logic [NUM_PRIO-1:0][OW-1:0] occ_q, occ_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        overflow_q, overflow_d;

  logic [NUM_PRIO-1:0] non_empty_c;
  logic [NUM_PRIO-1:0] push_lvl_c;
  logic [NUM_PRIO-1:0] pop_lvl_c;
  logic [NSEL-1:0]     sel_ready_c;
  logic                push_c;
  logic                pop_c;
  logic [PW-1:0]       strict_c;
  logic [PW-1:0]       grant_c;

  // Out-of-range priority codes map to a permanently "full" slot.
  for (genvar g = 0; g < NSEL; g++) begin : g_sel
    if (g < NUM_PRIO) begin : g_lvl
      assign sel_ready_c[g] = (occ_q[g] != OW'(DEPTH));
    end else begin : g_none
      assign sel_ready_c[g] = 1'b0;
    end
  end

  assign in_ready  = sel_ready_c[in_prio];
  assign out_valid = |non_empty_c;
  assign out_prio  = grant_c;
  assign count     = count_q;
  assign overflow  = overflow_q;

  assign push_c = in_valid && in_ready && !flush;
  assign pop_c  = out_valid && out_ready && !flush;

  for (genvar g = 0; g < NUM_PRIO; g++) begin : g_level
    assign non_empty_c[g] = (occ_q[g] != '0);
    assign push_lvl_c[g]  = push_c && (in_prio == PW'(g));
    assign pop_lvl_c[g]   = pop_c && (grant_c == PW'(g));
  end

  // Lowest-index non-empty level wins.
  always_comb begin
    strict_c = '0;
    for (int i = NUM_PRIO - 1; i >= 0; i--) begin
      if (non_empty_c[i]) strict_c = PW'(i);
    end
  end

`ifdef PRIO_TASK_QUEUE_ANTI_STARVE_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;

  logic [SW-1:0] starve_q, starve_d;
  logic [PW-1:0] oldest_c;
  logic          force_c;
  logic          lower_busy_c;

  // Counts consecutive pops that bypassed a waiting lower-priority level.
  always_comb begin
    oldest_c = '0;
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (non_empty_c[i]) oldest_c = PW'(i);
    end
    force_c = (starve_q == SW'(STARVE_LIMIT));
    grant_c = force_c ? oldest_c : strict_c;
    lower_busy_c = 1'b0;
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (non_empty_c[i] && (PW'(i) > grant_c)) lower_busy_c = 1'b1;
    end
    starve_d = starve_q;
    if (flush) begin
      starve_d = '0;
    end else if (pop_c) begin
      starve_d = (lower_busy_c && !force_c) ? starve_q + SW'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign grant_c = strict_c;
`endif

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (grant_c == PW'(i)) out_data = mem_q[i][head_q[i]];
    end
  end

  // Pointer, occupancy and count update; flush overrides the cycle's push and pop.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    count_d    = count_q + CW'(push_c) - CW'(pop_c);
    overflow_d = in_valid && !in_ready && !flush;
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (push_lvl_c[i]) tail_d[i] = tail_q[i] + AW'(1);
      if (pop_lvl_c[i])  head_d[i] = head_q[i] + AW'(1);
      occ_d[i] = occ_q[i] + OW'(push_lvl_c[i]) - OW'(pop_lvl_c[i]);
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      occ_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (push_lvl_c[i]) mem_q[i][tail_q[i]] <= in_data;
    end
  end

endmodule

// File: tb/tb_prio_task_queue.sv
// Directed self-checking bench for prio_task_queue at default parameters.
module tb_prio_task_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_prio;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_prio;
  logic       flush;
  logic [5:0] count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  prio_task_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_prio(in_prio),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_prio(out_prio),
    .flush(flush), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic idle();
    in_valid = 1'b0; in_data = 8'h00; in_prio = 2'd0; out_ready = 1'b0; flush = 1'b0;
  endtask

  // Called at a falling edge; applies one cycle of inputs and returns at the next falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic [1:0] p,
                      input logic r, input logic f);
    in_valid = v; in_data = d; in_prio = p; out_ready = r; flush = f;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_priority();
    in_valid = 1'b1; in_data = 8'hA1; in_prio = 2'd2;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prio_pre_push_valid got=%0b exp=0", out_valid); end
    @(posedge clk); #1; idle(); @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL prio_latency_valid got=%0b exp=1", out_valid); end
    step(1'b1, 8'hB2, 2'd0, 1'b0, 1'b0);
    checks++; if (count !== 6'd2) begin errors++; $display("FAIL prio_count2 got=%0d exp=2", count); end
    checks++; if (out_data !== 8'hB2) begin errors++; $display("FAIL prio_first_data got=%0h exp=b2", out_data); end
    checks++; if (out_prio !== 2'd0) begin errors++; $display("FAIL prio_first_prio got=%0d exp=0", out_prio); end
    step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL prio_count1 got=%0d exp=1", count); end
    checks++; if (out_data !== 8'hA1) begin errors++; $display("FAIL prio_second_data got=%0h exp=a1", out_data); end
    checks++; if (out_prio !== 2'd2) begin errors++; $display("FAIL prio_second_prio got=%0d exp=2", out_prio); end
    step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL prio_count0 got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prio_empty_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_full();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) step(1'b1, 8'(16 + i), 2'd1, 1'b0, 1'b0);
    checks++; if (count !== 6'd8) begin errors++; $display("FAIL full_count got=%0d exp=8", count); end
    in_valid = 1'b1; in_data = 8'h99; in_prio = 2'd1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_l1 got=%0b exp=0", in_ready); end
    in_prio = 2'd0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_l0 got=%0b exp=1", in_ready); end
    in_prio = 2'd1;
    @(posedge clk); #1; idle(); @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow got=%0b exp=1", overflow); end
    checks++; if (count !== 6'd8) begin errors++; $display("FAIL full_count_after_reject got=%0d exp=8", count); end
    // Full level popped and pushed together: push still rejected.
    in_valid = 1'b1; in_data = 8'h77; in_prio = 2'd1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL drain_data0 got=%0h exp=10", out_data); end
    @(posedge clk); #1; idle(); @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_pop_overflow got=%0b exp=1", overflow); end
    checks++; if (count !== 6'd7) begin errors++; $display("FAIL full_pop_count got=%0d exp=7", count); end
    for (int i = 1; i < 8; i++) begin
      exp = 8'(16 + i);
      checks++; if (out_data !== exp) begin errors++; $display("FAIL drain_data%0d got=%0h exp=%0h", i, out_data, exp); end
      checks++; if (out_prio !== 2'd1) begin errors++; $display("FAIL drain_prio%0d got=%0d exp=1", i, out_prio); end
      step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b exp=0", out_valid); end
    step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL drain_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_same_level();
    logic [7:0] tail_exp [5];
    tail_exp = '{8'h34, 8'h40, 8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 2'd3, 1'b0, 1'b0);
    checks++; if (count !== 6'd5) begin errors++; $display("FAIL same_count_init got=%0d exp=5", count); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data !== 8'(8'h30 + k)) begin errors++; $display("FAIL same_data%0d got=%0h exp=%0h", k, out_data, 8'(8'h30 + k)); end
      step(1'b1, 8'(8'h40 + k), 2'd3, 1'b1, 1'b0);
      checks++; if (count !== 6'd5) begin errors++; $display("FAIL same_count%0d got=%0d exp=5", k, count); end
    end
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_data !== tail_exp[k]) begin errors++; $display("FAIL same_drain%0d got=%0h exp=%0h", k, out_data, tail_exp[k]); end
      step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL same_final_count got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    logic [1:0] lv [6];
    lv = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), lv[i], 1'b0, 1'b0);
    checks++; if (count !== 6'd6) begin errors++; $display("FAIL flush_pre_count got=%0d exp=6", count); end
    step(1'b1, 8'hEE, 2'd0, 1'b1, 1'b1);
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow got=%0b exp=0", overflow); end
    step(1'b1, 8'h55, 2'd2, 1'b0, 1'b0);
    checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL flush_next_data got=%0h exp=55", out_data); end
    checks++; if (out_prio !== 2'd2) begin errors++; $display("FAIL flush_next_prio got=%0d exp=2", out_prio); end
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL flush_next_count got=%0d exp=1", count); end
    step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic test_starve();
    step(1'b1, 8'h33, 2'd3, 1'b0, 1'b0);
    step(1'b1, 8'h00, 2'd0, 1'b0, 1'b0);
`ifdef PRIO_TASK_QUEUE_ANTI_STARVE_EN
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_prio !== 2'd0 || out_data !== 8'(k)) begin errors++; $display("FAIL starve_pop%0d got=%0d/%0h exp=0/%0h", k, out_prio, out_data, 8'(k)); end
      step(1'b1, 8'(k + 1), 2'd0, 1'b1, 1'b0);
    end
    checks++; if (out_prio !== 2'd3 || out_data !== 8'h33) begin errors++; $display("FAIL starve_forced got=%0d/%0h exp=3/33", out_prio, out_data); end
`else
    for (int k = 0; k < 12; k++) begin
      checks++; if (out_prio !== 2'd0 || out_data !== 8'(k)) begin errors++; $display("FAIL strict_pop%0d got=%0d/%0h exp=0/%0h", k, out_prio, out_data, 8'(k)); end
      step(1'b1, 8'(k + 1), 2'd0, 1'b1, 1'b0);
    end
    checks++; if (out_prio !== 2'd0 || out_data !== 8'd12) begin errors++; $display("FAIL strict_final got=%0d/%0h exp=0/0c", out_prio, out_data); end
`endif
    step(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL starve_cleanup got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] lv [5];
    lv = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd0};
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h61 + i), lv[i], 1'b0, 1'b0);
    checks++; if (count !== 6'd5) begin errors++; $display("FAIL rmid_pre_count got=%0d exp=5", count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%0b exp=0", out_valid); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL rmid_count got=%0d exp=0", count); end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h7A, 2'd3, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h7A || out_prio !== 2'd3) begin errors++; $display("FAIL rmid_next got=%0b/%0h/%0d exp=1/7a/3", out_valid, out_data, out_prio); end
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL rmid_next_count got=%0d exp=1", count); end
    step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    checks++; if (count !== 6'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_drain got=%0d/%0b exp=0/0", count, out_valid); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_full();
    test_same_level();
    test_flush();
    test_starve();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
